fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning instruction address width in words.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, meaning fetch request, valid for one cycle.
REQ-006 SHALL have port imem_addr, output, ADDR_W, meaning fetch address, valid with imem_req.
REQ-007 SHALL have port imem_rvalid, input, 1, meaning the response is present, one or more cycles after imem_req.
REQ-008 SHALL have port imem_rdata, input, 16, meaning the instruction word; opcode in [15:12].
REQ-009 SHALL have port instr_valid, output, 1, meaning an instruction is offered downstream.
REQ-010 SHALL have port instr_ready, input, 1, meaning downstream accepts; transfer when instr_valid and instr_ready are both high.
REQ-011 SHALL have port instr_data, output, 16, meaning the offered instruction word.
REQ-012 SHALL have port instr_pc, output, ADDR_W, meaning the address of instr_data.
REQ-013 SHALL have port redirect_valid, input, 1, meaning a taken control transfer, one cycle.
REQ-014 SHALL have port redirect_pc, input, ADDR_W, meaning the target address.
REQ-015 SHALL have port halted, output, 1, meaning the sequencer has stopped.

Function
REQ-016 SHALL implement states FETCH, WAIT, ISSUE and HALT.
- FETCH: imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
REQ-017 SHALL, in WAIT, capture imem_rdata when imem_rvalid is high and go to ISSUE; with imem_rvalid low it SHALL stay in WAIT, with no timeout.
REQ-018 SHALL hold instr_valid high in ISSUE, with instr_data and instr_pc stable until the transfer.
REQ-019 SHALL, on a transfer, set pc to pc+1 modulo 2^ADDR_W, so the maximum address wraps to 0.
- Next state is FETCH.
- If the transferred opcode is in the halt category, next state is HALT instead.
REQ-020 SHALL treat opcodes 0110, 1000 and 1001-1111 as the halt category.
- Opcodes 0000-0101 and 0111 proceed normally.
REQ-021 SHALL, in HALT, hold halted=1, imem_req=0 and instr_valid=0.
- HALT is left only by reset.
REQ-022 SHALL, on redirect_valid outside HALT, set pc to redirect_pc and go to FETCH on the next cycle, with priority over every other event in the same cycle:
- FETCH: the issued request is abandoned.
- WAIT: the pending response is squashed; a later imem_rvalid for it is ignored, and the new imem_req is withheld until it arrives.
- ISSUE: the held instruction is dropped, even if instr_ready is high that cycle.
REQ-023 SHALL ignore redirect_valid in HALT.
REQ-024 SHALL never have more than one imem request outstanding.
REQ-025 SHALL ignore imem_rvalid in any state other than WAIT, except as REQ-022 allows.

Reset
REQ-026 SHALL, while rst_n is low, drive the following, independent of clk:
- state FETCH, pc=RESET_PC, squash flag clear;
- imem_req=0, instr_valid=0, halted=0, instr_data=0, instr_pc=0.
REQ-027 SHALL assert the first imem_req, with addr=RESET_PC, in the first cycle after rst_n deasserts.
REQ-028 SHALL, on reset during WAIT or ISSUE, discard all in-flight state; a response arriving after reset is ignored.

Configuration
REQ-029 SHALL, with FETCH_STALL_CNT_EN defined, add output stall_cnt, 16 bits, reset to 0.
- stall_cnt increments on each cycle with instr_valid=1 and instr_ready=0.
- stall_cnt saturates at 0xFFFF.
REQ-030 SHALL, without FETCH_STALL_CNT_EN, have no stall_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset; memory returns 0x0123 at addr 0 after 1 cycle; instr_ready=1 -> instr_data=0x0123, instr_pc=0, next imem_addr=1.
REQ-032 SHALL cover: instr_ready held low 5 cycles in ISSUE -> instr_valid and instr_data stable, no imem_req; with the macro, stall_cnt=5.
REQ-033 SHALL cover: redirect_valid with redirect_pc=0x40 while in WAIT -> stale response ignored, next imem_addr=0x40, no instr_valid for the stale word.
REQ-034 SHALL cover: fetch of 0x6000 accepted -> halted=1 next cycle, imem_req stays 0 for 20 cycles, redirect ignored.
REQ-035 SHALL cover: pc=0xFF with ADDR_W=8, transfer -> next imem_addr=0x00.
REQ-036 SHALL cover: rst_n low mid-WAIT -> outputs at reset values immediately; first request after release uses addr=RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: FETCH -> WAIT -> ISSUE loop with redirect squashing and a sticky HALT.
// Optional FETCH_STALL_CNT_EN adds a saturating 16-bit downstream stall counter output (stall_cnt).
module fetch_sequencer #(
    parameter int                 ADDR_W   = 8,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [15:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [15:0]       instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_ISSUE, ST_HALT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                squash_q, squash_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic                halted_q, halted_d;
    logic [15:0]         data_q, data_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;
    logic [ADDR_W-1:0]   pc_inc;
    logic                is_halt_op;
    logic                pending;

    assign pc_inc     = pc_q + ADDR_W'(1);
    assign is_halt_op = (data_q[15:12] == 4'b0110) || data_q[15];

    // A request is still owed a response if one was issued and its rvalid has not yet been seen.
    assign pending = ((state_q == ST_WAIT) && !imem_rvalid) ||
                     ((state_q == ST_FETCH) && (req_q || (squash_q && !imem_rvalid)));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        data_d   = data_q;
        ipc_d    = ipc_q;
        if (redirect_valid && (state_q != ST_HALT)) begin
            state_d  = ST_FETCH;
            pc_d     = redirect_pc;
            squash_d = pending;
            req_d    = !pending;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    // req_q low here means either the first cycle after reset or a squash drain.
                    if (req_q) begin
                        req_d   = 1'b0;
                        state_d = ST_WAIT;
                    end else if (!squash_q || imem_rvalid) begin
                        req_d    = 1'b1;
                        squash_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        data_d  = imem_rdata;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        pc_d    = pc_inc;
                        if (is_halt_op) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                            req_d   = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            data_q   <= 16'h0000;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else if (valid_q && !instr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: linear stimulus, immediate assertions at every check point.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [7:0]  instr_pc;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

`define CHK(TAG, OBS, EXP) \
    begin \
        n_chk++; \
        assert ((OBS) === (EXP)) else begin \
            n_fail++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 16'h0000;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;

        // Reset values before any clock edge
        #3;
        `CHK("rst_req",    imem_req,    1'b0)
        `CHK("rst_valid",  instr_valid, 1'b0)
        `CHK("rst_halted", halted,      1'b0)
        `CHK("rst_data",   instr_data,  16'h0000)
        `CHK("rst_ipc",    instr_pc,    8'h00)
`ifdef FETCH_STALL_CNT_EN
        `CHK("rst_stall", stall_cnt, 16'h0000)
`endif
        tick();
        tick();
        `CHK("rst_req_clk", imem_req, 1'b0)
        rst_n = 1'b1;

        // First request after release, then basic fetch/issue of 0x0123
        tick();
        `CHK("first_req",  imem_req,  1'b1)
        `CHK("first_addr", imem_addr, 8'h00)
        tick();
        `CHK("wait_req", imem_req, 1'b0)
        imem_rvalid = 1'b1; imem_rdata = 16'h0123; instr_ready = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        `CHK("t1_valid", instr_valid, 1'b1)
        `CHK("t1_data",  instr_data,  16'h0123)
        `CHK("t1_pc",    instr_pc,    8'h00)
        $display("xfer data=%h pc=%h", instr_data, instr_pc);
        tick();
        `CHK("t1_next_req",   imem_req,    1'b1)
        `CHK("t1_next_addr",  imem_addr,   8'h01)
        `CHK("t1_valid_drop", instr_valid, 1'b0)
        instr_ready = 1'b0;

        // Downstream stall for 5 cycles
        tick();
        imem_rvalid = 1'b1; imem_rdata = 16'h1234;
        tick();
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++;
            if (instr_valid !== 1'b1) begin
                n_fail++;
                $error("FAIL stall_valid: observed %0h expected 1", instr_valid);
            end
            n_chk++;
            if (instr_data !== 16'h1234) begin
                n_fail++;
                $error("FAIL stall_data: observed %0h expected 1234", instr_data);
            end
            n_chk++;
            if (instr_pc !== 8'h01) begin
                n_fail++;
                $error("FAIL stall_pc: observed %0h expected 01", instr_pc);
            end
            n_chk++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $error("FAIL stall_req: observed %0h expected 0", imem_req);
            end
        end
`ifdef FETCH_STALL_CNT_EN
        `CHK("stall_cnt", stall_cnt, 16'h0005)
`endif
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        `CHK("t2_next_addr", imem_addr, 8'h02)
        `CHK("t2_next_req",  imem_req,  1'b1)
        $display("xfer data=1234 pc=01 after stall");

        // Redirect to 0x40 while waiting; stale response must be dropped
        tick();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect_valid = 1'b0;
        `CHK("redir_withhold0", imem_req, 1'b0)
        tick();
        `CHK("redir_withhold1", imem_req, 1'b0)
        imem_rvalid = 1'b1; imem_rdata = 16'h5555;
        tick();
        imem_rvalid = 1'b0;
        `CHK("redir_req",       imem_req,    1'b1)
        `CHK("redir_addr",      imem_addr,   8'h40)
        `CHK("redir_no_stale0", instr_valid, 1'b0)
        tick();
        `CHK("redir_no_stale1", instr_valid, 1'b0)
        imem_rvalid = 1'b1; imem_rdata = 16'h0042;
        tick();
        imem_rvalid = 1'b0;
        `CHK("redir_valid", instr_valid, 1'b1)
        `CHK("redir_data",  instr_data,  16'h0042)
        `CHK("redir_pc",    instr_pc,    8'h40)
        $display("issue data=%h pc=%h after redirect", instr_data, instr_pc);

        // Redirect in ISSUE beats a simultaneous transfer
        redirect_valid = 1'b1; redirect_pc = 8'hFF; instr_ready = 1'b1;
        tick();
        redirect_valid = 1'b0; instr_ready = 1'b0;
        `CHK("drop_valid", instr_valid, 1'b0)
        `CHK("drop_req",   imem_req,    1'b1)
        `CHK("drop_addr",  imem_addr,   8'hFF)

        // Address wrap 0xFF -> 0x00
        tick();
        imem_rvalid = 1'b1; imem_rdata = 16'h7ABC;
        tick();
        imem_rvalid = 1'b0;
        `CHK("wrap_pc",   instr_pc,   8'hFF)
        `CHK("wrap_data", instr_data, 16'h7ABC)
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        `CHK("wrap_addr", imem_addr, 8'h00)
        `CHK("wrap_req",  imem_req,  1'b1)
        $display("xfer data=7abc pc=ff, next addr=%h", imem_addr);

        // Halt opcode 0110
        tick();
        imem_rvalid = 1'b1; imem_rdata = 16'h6000;
        tick();
        imem_rvalid = 1'b0;
        `CHK("halt_pre_valid",  instr_valid, 1'b1)
        `CHK("halt_pre_halted", halted,      1'b0)
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        `CHK("halt_halted", halted,      1'b1)
        `CHK("halt_valid",  instr_valid, 1'b0)
        `CHK("halt_req",    imem_req,    1'b0)
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i == 3);
            redirect_pc    = 8'h10;
            imem_rvalid    = (i == 7);
            tick();
            n_chk++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $error("FAIL halt_hold_req: observed %0h expected 0", imem_req);
            end
            n_chk++;
            if (halted !== 1'b1) begin
                n_fail++;
                $error("FAIL halt_hold_halted: observed %0h expected 1", halted);
            end
            n_chk++;
            if (instr_valid !== 1'b0) begin
                n_fail++;
                $error("FAIL halt_hold_valid: observed %0h expected 0", instr_valid);
            end
        end
        redirect_valid = 1'b0; imem_rvalid = 1'b0;
        $display("halted held for 20 cycles");

        // Leave HALT by reset, then reset again mid-WAIT
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        `CHK("unhalt", halted, 1'b0)
        tick();
        `CHK("re_req", imem_req, 1'b1)
        tick();
        imem_rvalid = 1'b1; imem_rdata = 16'h0ABC; instr_ready = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        `CHK("re_data", instr_data, 16'h0ABC)
        tick();
        instr_ready = 1'b0;
        `CHK("re_addr", imem_addr, 8'h01)
        tick();
        `CHK("re_wait_req", imem_req, 1'b0)
        #2;
        rst_n = 1'b0;
        #1;
        `CHK("mid_rst_req",    imem_req,    1'b0)
        `CHK("mid_rst_valid",  instr_valid, 1'b0)
        `CHK("mid_rst_halted", halted,      1'b0)
        `CHK("mid_rst_data",   instr_data,  16'h0000)
        `CHK("mid_rst_ipc",    instr_pc,    8'h00)
        tick();
        imem_rvalid = 1'b1; imem_rdata = 16'hDEAD;
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        `CHK("post_rst_req",   imem_req,    1'b1)
        `CHK("post_rst_addr",  imem_addr,   8'h00)
        `CHK("post_rst_valid", instr_valid, 1'b0)
        tick();
        `CHK("post_rst_wait_req",   imem_req,    1'b0)
        `CHK("post_rst_wait_valid", instr_valid, 1'b0)
        $display("reset mid-wait, refetch addr=00");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
